apb_sl_fifo_bridge: RTL

// - APB3 slave at the host end of the SL-transceiver command path. Turns APB writes into
//   34-bit {modifier[1:0], data[31:0]} words pushed into the command FIFO, and APB reads

---
 rtl/sl_bridge_pkg.sv | 39 +++
 rtl/sl_wait_timer.sv | 24 ++
 rtl/apb_sl_fifo_bridge.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sl_bridge_pkg.sv
// Shared definitions for the host-side and channel-side SL bridges:
// FIFO word layout, modifier codes and the APB register map.
package sl_bridge_pkg;
  localparam int FIFO_WORD_W = 34;

  localparam logic [1:0] MOD_CONFIG  = 2'd0;
  localparam logic [1:0] MOD_DATA    = 2'd1;
  localparam logic [1:0] MOD_STATUS  = 2'd2;
  localparam logic [1:0] MOD_CHANNEL = 2'd3;

  // Register word indices, i.e. paddr[4:2]
  localparam logic [2:0] REG_CFG  = 3'd0;
  localparam logic [2:0] REG_DATA = 3'd1;
  localparam logic [2:0] REG_STAT = 3'd2;
  localparam logic [2:0] REG_CHAN = 3'd3;
  localparam logic [2:0] REG_RSP  = 3'd4;
  localparam logic [2:0] REG_RMOD = 3'd5;

  typedef struct packed {
    logic [1:0]  mod;
    logic [31:0] data;
  } fifo_word_t;

  function automatic logic is_push_reg(input logic [2:0] idx);
    return (idx == REG_CFG) || (idx == REG_DATA) || (idx == REG_CHAN);
  endfunction

  function automatic logic is_read_reg(input logic [2:0] idx);
    return (idx == REG_STAT) || (idx == REG_RSP) || (idx == REG_RMOD);
  endfunction

  function automatic logic [1:0] push_mod(input logic [2:0] idx);
    case (idx)
      REG_CFG:  return MOD_CONFIG;
      REG_DATA: return MOD_DATA;
      default:  return MOD_CHANNEL;
    endcase
  endfunction
endpackage

// File: rtl/sl_wait_timer.sv
// Saturating wait counter; expired flags the cycle whose increment reaches TIMEOUT.
module sl_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     count <= '0;
    else if (clear)                 count <= '0;
    else if (enable && count != MAX) count <= count + 1'b1;
  end

  assign expired = enable && (count >= LAST);
endmodule

// File: rtl/apb_sl_fifo_bridge.sv
// APB3 slave turning writes into command-FIFO pushes and RSP reads into
// response-FIFO pops, with bounded waiting on full/empty.
module apb_sl_fifo_bridge
  import sl_bridge_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_W-1:0]      paddr,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic                   fifo_cmd_full,
  output logic [FIFO_WORD_W-1:0] fifo_cmd_data,
  output logic                   fifo_cmd_inc,
  input  logic                   fifo_rsp_empty,
  input  logic [FIFO_WORD_W-1:0] fifo_rsp_data,
  output logic                   fifo_rsp_inc,
  output logic                   irq_rsp
);
  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_DECODE = 5'b00010;
  localparam logic [4:0] S_WAIT   = 5'b00100;
  localparam logic [4:0] S_DONE   = 5'b01000;
  localparam logic [4:0] S_ERR    = 5'b10000;

  logic [4:0]  state, nxt;
  logic [2:0]  idx;
  logic        wr;
  logic [1:0]  last_rsp_mod;
  logic        is_push, is_pop, legal, blocked, expired;
  logic        done_nxt, err_nxt;
  logic [31:0] rd_mux;
  fifo_word_t  rsp, cmd_word;
  logic        unused_addr;

  // Only paddr[4:2] selects a register; the rest alias.
  assign unused_addr = ^paddr;
  assign rsp         = fifo_rsp_data;

  assign is_push = wr && is_push_reg(idx);
  assign is_pop  = !wr && (idx == REG_RSP);
  assign legal   = is_push || (!wr && is_read_reg(idx));
  assign blocked = (is_push && fifo_cmd_full) || (is_pop && fifo_rsp_empty);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (psel && !penable) nxt = S_DECODE;
      S_DECODE: nxt = !legal ? S_ERR : (blocked ? S_WAIT : S_DONE);
      S_WAIT:   if (!blocked) nxt = S_DONE;
                else if (expired) nxt = S_ERR;
      S_DONE:   nxt = S_IDLE;
      S_ERR:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign done_nxt = (nxt == S_DONE);
  assign err_nxt  = (nxt == S_ERR);

  // Read data is loaded on the edge into DONE, before the pop advances the head.
  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_STAT: rd_mux = {28'b0, last_rsp_mod, fifo_rsp_empty, fifo_cmd_full};
      REG_RSP:  rd_mux = rsp.data;
      REG_RMOD: rd_mux = {30'b0, last_rsp_mod};
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    cmd_word.mod  = push_mod(paddr[4:2]);
    cmd_word.data = pwdata;
  end

  sl_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == S_DECODE),
    .enable  (state == S_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      wr            <= 1'b0;
      last_rsp_mod  <= MOD_CONFIG;
      fifo_cmd_data <= '0;
      prdata        <= '0;
      pready        <= 1'b0;
      pslverr       <= 1'b0;
      fifo_cmd_inc  <= 1'b0;
      fifo_rsp_inc  <= 1'b0;
      irq_rsp       <= 1'b0;
    end else begin
      state        <= nxt;
      irq_rsp      <= !fifo_rsp_empty;
      pready       <= done_nxt || err_nxt;
      pslverr      <= err_nxt;
      fifo_cmd_inc <= done_nxt && wr;
      fifo_rsp_inc <= done_nxt && is_pop;
      prdata       <= (done_nxt && !wr) ? rd_mux : '0;
      if (done_nxt && is_pop) last_rsp_mod <= rsp.mod;
      if (nxt == S_DECODE) begin
        idx           <= paddr[4:2];
        wr            <= pwrite;
        fifo_cmd_data <= (pwrite && is_push_reg(paddr[4:2])) ? cmd_word : '0;
      end else if (nxt == S_IDLE) begin
        fifo_cmd_data <= '0;
      end
    end
  end
endmodule
